// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI memory arbiter.
//   arb_state_e : arbiter FSM states (idle, m0 read, m1 read, m1 write)
//   RESP_*      : AXI response encodings (passed through, never generated)
//   SIZE_*      : AXI transfer size encodings (passed through unchanged)
//   is_m1()     : true when a state belongs to master 1
package axi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD0  = 2'd1,
    ARB_RD1  = 2'd2,
    ARB_WR1  = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  function automatic logic is_m1(input arb_state_e s);
    return (s == ARB_RD1) || (s == ARB_WR1);
  endfunction

endpackage

// File: rtl/axi_arb_grant.sv
// Combinational grant picker for the AXI memory arbiter.
// Config macro: ARB_ROUND_ROBIN_EN selects round-robin between the two
// masters (rr_m1_i = master 1 was granted last); otherwise fixed priority
// wr1 > rd1 > rd0. Inside master 1 a write always beats a read.
//   rd0_i    : master 0 read request
//   rd1_i    : master 1 read request
//   wr1_i    : master 1 complete write request (AW and W both valid)
//   rr_m1_i  : last granted master was m1 (round-robin build only)
//   grant_o  : next state, ARB_IDLE when nothing is requested
module axi_arb_grant
  import axi_pkg::*;
(
  input  logic       rd0_i,
  input  logic       rd1_i,
  input  logic       wr1_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       rr_m1_i,
`endif
  output logic [1:0] grant_o
);

  arb_state_e grant;
  arb_state_e m1_pick;
  logic       m1_req;

  always_comb begin
    grant   = ARB_IDLE;
    m1_pick = wr1_i ? ARB_WR1 : ARB_RD1;
    m1_req  = wr1_i | rd1_i;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the master that did not win last time goes first.
    if (m1_req && rd0_i) begin
      grant = rr_m1_i ? ARB_RD0 : m1_pick;
    end else if (m1_req) begin
      grant = m1_pick;
    end else if (rd0_i) begin
      grant = ARB_RD0;
    end
`else
    if (m1_req) begin
      grant = m1_pick;
    end else if (rd0_i) begin
      grant = ARB_RD0;
    end
`endif
  end

  assign grant_o = grant;

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI4-Lite-style arbiter, one transaction in flight.
// Master 0 (instruction fetch) reads only; master 1 (load/store) reads and
// writes. The grant is decided in IDLE, takes effect on the next edge, and
// is held until the slave's response handshake, then returns to IDLE.
// Config macro: ARB_ROUND_ROBIN_EN (round-robin between masters; default is
// fixed priority m1 write > m1 read > m0 read).
// Ports:
//   i_clock, i_reset_n       : clock, asynchronous active-low reset
//   i_m0_ar* / o_m0_r*       : master 0 read address / read data
//   i_m1_ar* / o_m1_r*       : master 1 read address / read data
//   i_m1_aw*, i_m1_w*, o_m1_b*: master 1 write address / data / response
//   o_s_* / i_s_*            : slave-side mirror of all channels (wlast = 1)
module axi_mem_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  // master 0 read
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  input  logic [2:0]          i_m0_arsize,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  output logic                o_m0_rlast,
  // master 1 read
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  input  logic [2:0]          i_m1_arsize,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  output logic                o_m1_rlast,
  // master 1 write
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic                i_m1_awvalid,
  output logic                o_m1_awready,
  input  logic [2:0]          i_m1_awsize,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  input  logic                i_m1_wvalid,
  output logic                o_m1_wready,
  output logic [1:0]          o_m1_bresp,
  output logic                o_m1_bvalid,
  input  logic                i_m1_bready,
  // slave side
  output logic [ADDR_W-1:0]   o_s_araddr,
  output logic                o_s_arvalid,
  input  logic                i_s_arready,
  output logic [2:0]          o_s_arsize,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  input  logic                i_s_rvalid,
  output logic                o_s_rready,
  input  logic                i_s_rlast,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  output logic                o_s_awvalid,
  input  logic                i_s_awready,
  output logic [2:0]          o_s_awsize,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic                o_s_wvalid,
  input  logic                i_s_wready,
  output logic                o_s_wlast,
  input  logic [1:0]          i_s_bresp,
  input  logic                i_s_bvalid,
  output logic                o_s_bready
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] grant;

  logic rd_arvalid;
  logic rd_rready;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_m1_q, rr_m1_d;
`endif

  axi_arb_grant u_grant (
    .rd0_i   (i_m0_arvalid),
    .rd1_i   (i_m1_arvalid),
    .wr1_i   (i_m1_awvalid & i_m1_wvalid),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_m1_i (rr_m1_q),
`endif
    .grant_o (grant)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ARB_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_m1_q <= 1'b1;
    end else begin
      rr_m1_q <= rr_m1_d;
    end
  end

  always_comb begin
    rr_m1_d = rr_m1_q;
    if (state_q == ARB_IDLE && arb_state_e'(grant) != ARB_IDLE) begin
      rr_m1_d = is_m1(arb_state_e'(grant));
    end
  end
`endif

  // Payload fields are forwarded unconditionally; only the valid/ready
  // handshakes are gated by the grant.
  assign o_s_araddr = (state_q == ARB_RD0) ? i_m0_araddr : i_m1_araddr;
  assign o_s_arsize = (state_q == ARB_RD0) ? i_m0_arsize : i_m1_arsize;
  assign o_s_awaddr = i_m1_awaddr;
  assign o_s_awsize = i_m1_awsize;
  assign o_s_wdata  = i_m1_wdata;
  assign o_s_wstrb  = i_m1_wstrb;
  assign o_s_wlast  = 1'b1;
  assign o_m0_rdata = i_s_rdata;
  assign o_m0_rresp = i_s_rresp;
  assign o_m0_rlast = i_s_rlast;
  assign o_m1_rdata = i_s_rdata;
  assign o_m1_rresp = i_s_rresp;
  assign o_m1_rlast = i_s_rlast;
  assign o_m1_bresp = i_s_bresp;

  assign rd_arvalid = (state_q == ARB_RD0) ? i_m0_arvalid : i_m1_arvalid;
  assign rd_rready  = (state_q == ARB_RD0) ? i_m0_rready  : i_m1_rready;

  always_comb begin
    state_d      = state_q;
    ar_done_d    = ar_done_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    o_s_arvalid  = 1'b0;
    o_s_rready   = 1'b0;
    o_s_awvalid  = 1'b0;
    o_s_wvalid   = 1'b0;
    o_s_bready   = 1'b0;
    o_m0_arready = 1'b0;
    o_m0_rvalid  = 1'b0;
    o_m1_arready = 1'b0;
    o_m1_rvalid  = 1'b0;
    o_m1_awready = 1'b0;
    o_m1_wready  = 1'b0;
    o_m1_bvalid  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        state_d = arb_state_e'(grant);
      end

      ARB_RD0, ARB_RD1: begin
        o_s_arvalid = rd_arvalid & ~ar_done_q;
        o_s_rready  = rd_rready;
        if (state_q == ARB_RD0) begin
          o_m0_arready = i_s_arready & ~ar_done_q;
          o_m0_rvalid  = i_s_rvalid;
        end else begin
          o_m1_arready = i_s_arready & ~ar_done_q;
          o_m1_rvalid  = i_s_rvalid;
        end
        if (rd_arvalid && !ar_done_q && i_s_arready) begin
          ar_done_d = 1'b1;
        end
        // An early response is forwarded; only its handshake ends the grant.
        if (i_s_rvalid && rd_rready && i_s_rlast) begin
          state_d   = ARB_IDLE;
          ar_done_d = 1'b0;
        end
      end

      ARB_WR1: begin
        o_s_awvalid  = i_m1_awvalid & ~aw_done_q;
        o_s_wvalid   = i_m1_wvalid & ~w_done_q;
        // Once a half is accepted its ready stays high so a master waiting
        // for both readies together still sees them in one cycle.
        o_m1_awready = aw_done_q | i_s_awready;
        o_m1_wready  = w_done_q | i_s_wready;
        o_m1_bvalid  = i_s_bvalid;
        o_s_bready   = i_m1_bready;
        if (i_m1_awvalid && !aw_done_q && i_s_awready) begin
          aw_done_d = 1'b1;
        end
        if (i_m1_wvalid && !w_done_q && i_s_wready) begin
          w_done_d = 1'b1;
        end
        if (i_s_bvalid && i_m1_bready) begin
          state_d   = ARB_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule
